lsu_dual_arbiter: RTL and testbench
===================================

Name: lsu_dual_arbiter

Overview:
Sequences the two LSU-stage lanes of the dual-issue pipeline onto the single data-memory port.
- When both lanes carry a memory op, they are serviced in program order: lane 0, then lane 1.
- Holds the backend with mem_stall_o until the whole bundle is done.
- Sits between the EX/LSU pipeline registers, the data memory and the LSU/WB load-data path.

Parameters:
ADDR_W, 32, data-memory byte-address width.
MISALIGN_CHECK, 1, 1 = misaligned accesses are flagged and suppressed; 0 = issued unchecked.

Ports:
clock_i  in  1  system clock
reset_n_i  in  1  asynchronous active-low reset
advance_i  in  1  pipeline backend write-enable; LSU bundle moves to WB this edge
req_0_i / req_1_i  in  1  lane has a memory op
we_0_i / we_1_i  in  1  1 = store, 0 = load
funct3_0_i / funct3_1_i  in  3  RV32 size/sign code
addr_0_i / addr_1_i  in  ADDR_W  byte address (ALU result)
wdata_0_i / wdata_1_i  in  32  store data, unaligned (LSB-justified)
mem_stall_o  out  1  backend stall request
dmem_req_o  out  1  memory request
dmem_we_o  out  1  write strobe
dmem_addr_o  out  ADDR_W  word-aligned address (bits[1:0]=0)
dmem_wdata_o  out  32  lane-shifted store data
dmem_be_o  out  4  byte enables
dmem_ack_i  in  1  request accepted/completed, rdata valid
dmem_rdata_i  in  32  read word
ld_data_0_o / ld_data_1_o  out  32  aligned, extended load result
misalign_0_o / misalign_1_o  out  1  sticky per-bundle misalignment flag

Behaviour:
- Reset: everything below is forced asynchronously on reset_n_i low.
  - state=IDLE; all outputs 0.
  - dmem_req_o drops in the same cycle, even mid-transaction; a late ack is ignored.
- FSM states: IDLE, L0, L1, DONE.
  - IDLE: if req_0 go to L0; else if req_1 go to L1; else stay.
  - L0: on dmem_ack_i, go to L1 if req_1, else DONE.
  - L1: on dmem_ack_i, go to DONE.
  - DONE: stay until advance_i=1, then go to IDLE.
  - DONE exists so a bundle held in place by another stall source is never re-executed (no double stores).
- mem_stall_o (combinational):
  - 1 in L0 and L1.
  - 1 in IDLE when req_0|req_1.
  - 0 in DONE, and in IDLE with no request.
- Memory outputs:
  - dmem_req_o is 1 only in L0/L1, and stays high until ack.
  - Address, data and byte enables come from the active lane and are stable throughout.
  - Outside L0/L1, dmem_* = 0.
- Byte enables and store shifting use address bits [1:0]:
  - SB: be=0001<<a; wdata is the byte replicated into all four lanes.
  - SH: be=0011<<a; wdata is the halfword replicated.
  - SW: be=1111.
- Loads: on ack, ld_data_x_o is registered.
  - LB/LH are sign-extended; LBU/LHU zero-extended; LW taken as-is. Selection uses address bits [1:0].
  - Value holds until that lane's next load completes.
  - A store leaves ld_data unchanged.
- Misaligned access (MISALIGN_CHECK=1): halfword with a[0]=1, or word with a[1:0]≠0.
  - The lane is skipped: FSM passes through the state for one cycle with dmem_req_o=0.
  - misalign_x_o=1; ld_data_x_o=0.
  - Flags clear on the IDLE→L0/L1 transition of the next bundle.
- Latency with zero-wait memory (ack in first request cycle):
  - single-lane bundle: 2 stall cycles;
  - dual-lane bundle: 3 stall cycles;
  - no-request bundle: 0 stall cycles.
- Each wait state on dmem_ack_i adds 1 cycle.
- Input lanes are assumed stable while mem_stall_o=1 (the pipeline holds them); the block does not re-sample them.

Optional Feature:
Macro LSU_ARB_PERF_EN.
- Defined: adds ports perf_stall_cyc_o[31:0] and perf_dual_o[31:0].
  - perf_stall_cyc_o counts cycles with mem_stall_o=1.
  - perf_dual_o counts bundles with req_0&req_1, incremented on IDLE→L0.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Lane 0 LW addr 0x100, rdata 0xDEADBEEF, ack in first request cycle, advance_i=1 in DONE → mem_stall_o high 2 cycles; ld_data_0_o=0xDEADBEEF; one dmem_req_o pulse.
- Dual bundle: lane 0 SB 0x203 data 0xAB, lane 1 LH 0x202, rdata 0xAB120000 → lane 0 first with be=1000, wdata=0xABABABAB; then lane 1 with be=0000 read; ld_data_1_o=0xFFFFAB12; stall 3 cycles.
- Dual bundle, lane 0 ack delayed 2 cycles → stall 5 cycles; lane 1 request starts only after lane 0 ack.
- Store reaches DONE with advance_i=0 for 4 cycles → exactly one write; no new dmem_req_o until advance_i=1.
- LW at 0x102 (MISALIGN_CHECK=1) → misalign_0_o=1, dmem_req_o never asserted, ld_data_0_o=0.
- reset_n_i low while in L1 awaiting ack → dmem_req_o=0 and mem_stall_o=0 immediately; state IDLE; ack arriving after reset release has no effect.

Source files
------------

// File: rtl/lsu_dual_arbiter.sv
// lsu_dual_arbiter: serialises the two LSU lanes of a dual-issue bundle onto one data-memory port.
// Optional feature macro LSU_ARB_PERF_EN adds stall-cycle and dual-bundle performance counters.
module lsu_dual_arbiter #(
    parameter int ADDR_W         = 32,
    parameter bit MISALIGN_CHECK = 1'b1
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              advance_i,
    input  logic              req_0_i,
    input  logic              req_1_i,
    input  logic              we_0_i,
    input  logic              we_1_i,
    input  logic [2:0]        funct3_0_i,
    input  logic [2:0]        funct3_1_i,
    input  logic [ADDR_W-1:0] addr_0_i,
    input  logic [ADDR_W-1:0] addr_1_i,
    input  logic [31:0]       wdata_0_i,
    input  logic [31:0]       wdata_1_i,
    output logic              mem_stall_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [31:0]       dmem_wdata_o,
    output logic [3:0]        dmem_be_o,
    input  logic              dmem_ack_i,
    input  logic [31:0]       dmem_rdata_i,
    output logic [31:0]       ld_data_0_o,
    output logic [31:0]       ld_data_1_o,
    output logic              misalign_0_o,
    output logic              misalign_1_o,
    output logic [1:0]        state_o
`ifdef LSU_ARB_PERF_EN
    ,
    output logic [31:0]       perf_stall_cyc_o,
    output logic [31:0]       perf_dual_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        L0   = 2'd1,
        L1   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;

    logic              in_lane;
    logic              lane_sel;
    logic              act_we;
    logic [2:0]        act_f3;
    logic [ADDR_W-1:0] act_addr;
    logic [31:0]       act_wdata;
    logic              act_mis;
    logic              issue;
    logic              step;
    logic              bundle_start;
    logic [31:0]       load_value;

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        case (f3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = a[0];
            default: mis = (a != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = 4'b0011 << a;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] v;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  v = {{24{b[7]}}, b};
            3'b001:  v = {{16{h[15]}}, h};
            3'b100:  v = {24'd0, b};
            3'b101:  v = {16'd0, h};
            default: v = rd;
        endcase
        return v;
    endfunction

    // The lane being serviced is selected purely by state; inputs are held by the pipeline.
    always_comb begin
        in_lane   = 1'b0;
        lane_sel  = 1'b0;
        act_we    = 1'b0;
        act_f3    = 3'd0;
        act_addr  = '0;
        act_wdata = 32'd0;
        case (state)
            L0: begin
                in_lane   = 1'b1;
                act_we    = we_0_i;
                act_f3    = funct3_0_i;
                act_addr  = addr_0_i;
                act_wdata = wdata_0_i;
            end
            L1: begin
                in_lane   = 1'b1;
                lane_sel  = 1'b1;
                act_we    = we_1_i;
                act_f3    = funct3_1_i;
                act_addr  = addr_1_i;
                act_wdata = wdata_1_i;
            end
            default: ;
        endcase
    end

    assign act_mis      = in_lane && MISALIGN_CHECK && is_misaligned(act_f3, act_addr[1:0]);
    assign issue        = in_lane && !act_mis;
    assign step         = in_lane && (act_mis || dmem_ack_i);
    assign bundle_start = (state == IDLE) && (req_0_i || req_1_i);
    assign load_value   = load_extract(act_f3, act_addr[1:0], dmem_rdata_i);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_0_i)      next_state = L0;
                else if (req_1_i) next_state = L1;
            end
            L0:   if (step) next_state = req_1_i ? L1 : DONE;
            L1:   if (step) next_state = DONE;
            DONE: if (advance_i) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Memory handshake: dmem_req_o with stable addr/we/be/wdata is held until dmem_ack_i is
    // seen high on a rising clock edge; that edge completes the access and dmem_rdata_i is valid.
    always_comb begin
        mem_stall_o  = reset_n_i && (in_lane || bundle_start);
        dmem_req_o   = issue;
        dmem_we_o    = issue && act_we;
        dmem_addr_o  = issue ? {act_addr[ADDR_W-1:2], 2'b00} : '0;
        dmem_be_o    = (issue && act_we) ? store_be(act_f3, act_addr[1:0]) : 4'd0;
        dmem_wdata_o = (issue && act_we) ? store_data(act_f3, act_wdata) : 32'd0;
        state_o      = state;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= IDLE;
            ld_data_0_o  <= 32'd0;
            ld_data_1_o  <= 32'd0;
            misalign_0_o <= 1'b0;
            misalign_1_o <= 1'b0;
        end else begin
            state <= next_state;
            if (bundle_start) begin
                misalign_0_o <= 1'b0;
                misalign_1_o <= 1'b0;
            end
            // A skipped lane reports zero load data so a stale value is never forwarded.
            if (step) begin
                if (act_mis) begin
                    if (lane_sel) begin
                        misalign_1_o <= 1'b1;
                        ld_data_1_o  <= 32'd0;
                    end else begin
                        misalign_0_o <= 1'b1;
                        ld_data_0_o  <= 32'd0;
                    end
                end else if (!act_we) begin
                    if (lane_sel) ld_data_1_o <= load_value;
                    else          ld_data_0_o <= load_value;
                end
            end
        end
    end

`ifdef LSU_ARB_PERF_EN
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            perf_stall_cyc_o <= 32'd0;
            perf_dual_o      <= 32'd0;
        end else begin
            if (mem_stall_o)
                perf_stall_cyc_o <= perf_stall_cyc_o + 32'd1;
            if ((state == IDLE) && req_0_i && req_1_i)
                perf_dual_o <= perf_dual_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_dual_arbiter.sv
// Bench for lsu_dual_arbiter: directed bundles against a transaction-level model of the
// memory port, load results and misalignment flags.
module tb_lsu_dual_arbiter;

    localparam int ADDR_W = 32;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [7:0]  waits;
    } lane_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [7:0]  waits;
    } txn_t;

    // clock / reset
    logic              clock_i = 1'b0;
    logic              reset_n_i = 1'b0;
    always #5 clock_i = ~clock_i;

    logic              advance_i = 1'b0;
    logic              req_0_i = 1'b0, req_1_i = 1'b0;
    logic              we_0_i = 1'b0, we_1_i = 1'b0;
    logic [2:0]        funct3_0_i = 3'd0, funct3_1_i = 3'd0;
    logic [ADDR_W-1:0] addr_0_i = '0, addr_1_i = '0;
    logic [31:0]       wdata_0_i = 32'd0, wdata_1_i = 32'd0;
    logic              mem_stall_o, dmem_req_o, dmem_we_o;
    logic [ADDR_W-1:0] dmem_addr_o;
    logic [31:0]       dmem_wdata_o;
    logic [3:0]        dmem_be_o;
    logic              dmem_ack_i = 1'b0;
    logic [31:0]       dmem_rdata_i = 32'd0;
    logic [31:0]       ld_data_0_o, ld_data_1_o;
    logic              misalign_0_o, misalign_1_o;
    logic [1:0]        state_o;
`ifdef LSU_ARB_PERF_EN
    logic [31:0]       perf_stall_cyc_o, perf_dual_o;
`endif

    lsu_dual_arbiter #(.ADDR_W(ADDR_W), .MISALIGN_CHECK(1'b1)) dut (
        .clock_i(clock_i), .reset_n_i(reset_n_i), .advance_i(advance_i),
        .req_0_i(req_0_i), .req_1_i(req_1_i), .we_0_i(we_0_i), .we_1_i(we_1_i),
        .funct3_0_i(funct3_0_i), .funct3_1_i(funct3_1_i),
        .addr_0_i(addr_0_i), .addr_1_i(addr_1_i),
        .wdata_0_i(wdata_0_i), .wdata_1_i(wdata_1_i),
        .mem_stall_o(mem_stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .ld_data_0_o(ld_data_0_o), .ld_data_1_o(ld_data_1_o),
        .misalign_0_o(misalign_0_o), .misalign_1_o(misalign_1_o),
        .state_o(state_o)
`ifdef LSU_ARB_PERF_EN
        , .perf_stall_cyc_o(perf_stall_cyc_o), .perf_dual_o(perf_dual_o)
`endif
    );

    // scoreboard state
    txn_t        exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          stall_cnt = 0;
    int          req_cyc = 0;
    int          wr_cnt = 0;
    int          wait_cnt = 0;
    logic        chk_en = 1'b0;
    logic        force_ack = 1'b0;
    logic [3:0]  last_be = 4'd0;
    logic [31:0] last_wdata = 32'd0;
    logic [31:0] exp_ld0 = 32'd0, exp_ld1 = 32'd0;
    logic        exp_mis0 = 1'b0, exp_mis1 = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // model of the access rules
    function automatic int acc_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic is_mis(input lane_t l);
        return (l.addr % acc_bytes(l.f3)) != 0;
    endfunction

    function automatic logic [31:0] load_model(input lane_t l);
        int          n;
        logic [31:0] mask, v;
        n    = acc_bytes(l.f3);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v    = (l.rdata >> (8 * (l.addr % 4))) & mask;
        if (!l.f3[2] && ((v >> (8 * n - 1)) & 32'd1) != 0) v = v | ~mask;
        return v;
    endfunction

    function automatic lane_t mk_lane(input logic r, input logic w, input logic [2:0] f3,
                                      input logic [31:0] a, input logic [31:0] wd,
                                      input logic [31:0] rd, input int wt);
        lane_t l;
        l.req = r; l.we = w; l.f3 = f3; l.addr = a; l.wdata = wd; l.rdata = rd;
        l.waits = 8'(wt);
        return l;
    endfunction

    task automatic push_lane(input lane_t l);
        txn_t t;
        int   n;
        n       = acc_bytes(l.f3);
        t.addr  = l.addr - (l.addr % 4);
        t.we    = l.we;
        t.be    = l.we ? 4'(((1 << n) - 1) << (l.addr % 4)) : 4'd0;
        t.wdata = !l.we ? 32'd0 : (n == 1) ? l.wdata[7:0] * 32'h0101_0101 :
                  (n == 2) ? l.wdata[15:0] * 32'h0001_0001 : l.wdata;
        t.rdata = l.rdata;
        t.waits = l.waits;
        exp_q.push_back(t);
    endtask

    task automatic drive_lanes(input lane_t l0, input lane_t l1);
        req_0_i = l0.req; we_0_i = l0.we; funct3_0_i = l0.f3; addr_0_i = l0.addr; wdata_0_i = l0.wdata;
        req_1_i = l1.req; we_1_i = l1.we; funct3_1_i = l1.f3; addr_1_i = l1.addr; wdata_1_i = l1.wdata;
    endtask

    // compare process + memory responder, evaluated mid-cycle
    always @(negedge clock_i) begin
        if (!chk_en) begin
            dmem_ack_i   = force_ack;
            dmem_rdata_i = 32'hFFFF_FFFF;
        end else begin
            dmem_ack_i = 1'b0;
            if (dmem_req_o) begin
                req_cyc++;
                if (exp_q.size() == 0) begin
                    check("unexpected_req", {dmem_addr_o, dmem_we_o}, 0);
                end else begin
                    check("dmem_txn", {dmem_addr_o, dmem_we_o, dmem_be_o, dmem_wdata_o},
                          {exp_q[0].addr, exp_q[0].we, exp_q[0].be, exp_q[0].wdata});
                    if (wait_cnt == int'(exp_q[0].waits)) begin
                        dmem_ack_i   = 1'b1;
                        dmem_rdata_i = exp_q[0].rdata;
                        if (exp_q[0].we) begin
                            wr_cnt++;
                            last_be    = dmem_be_o;
                            last_wdata = dmem_wdata_o;
                        end
                        wait_cnt = 0;
                        void'(exp_q.pop_front());
                    end else begin
                        wait_cnt++;
                    end
                end
            end else begin
                check("dmem_idle_zero", {dmem_addr_o, dmem_we_o, dmem_be_o, dmem_wdata_o}, 0);
            end
            if (mem_stall_o) stall_cnt++;
        end
    end

    // driver: one bundle from issue to hand-off
    task automatic run_bundle(input lane_t l0, input lane_t l1, input int hold, output int stalls);
        logic m0, m1, done;
        int   exp_stall;
        m0 = l0.req && is_mis(l0);
        m1 = l1.req && is_mis(l1);
        if (l0.req && !m0) push_lane(l0);
        if (l1.req && !m1) push_lane(l1);
        exp_stall = 0;
        if (l0.req || l1.req) begin
            exp_stall = 1;
            exp_mis0  = 1'b0;
            exp_mis1  = 1'b0;
        end
        if (l0.req) begin
            exp_stall += 1 + (m0 ? 0 : int'(l0.waits));
            if (m0) begin exp_mis0 = 1'b1; exp_ld0 = 32'd0; end
            else if (!l0.we) exp_ld0 = load_model(l0);
        end
        if (l1.req) begin
            exp_stall += 1 + (m1 ? 0 : int'(l1.waits));
            if (m1) begin exp_mis1 = 1'b1; exp_ld1 = 32'd0; end
            else if (!l1.we) exp_ld1 = load_model(l1);
        end
        @(posedge clock_i); #1;
        drive_lanes(l0, l1);
        stall_cnt = 0;
        req_cyc   = 0;
        done      = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock_i); #1;
            if (!mem_stall_o) begin done = 1'b1; break; end
        end
        check("bundle_timeout", done, 1);
        check("stall_cycles", stall_cnt, exp_stall);
        check("queue_drained", exp_q.size(), 0);
        check("ld_data_0", ld_data_0_o, exp_ld0);
        check("ld_data_1", ld_data_1_o, exp_ld1);
        check("misalign_0", misalign_0_o, exp_mis0);
        check("misalign_1", misalign_1_o, exp_mis1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock_i); #1;
            check("done_hold_stall", mem_stall_o, 0);
        end
        advance_i = 1'b1;
        @(posedge clock_i); #1;
        advance_i = 1'b0;
        req_0_i   = 1'b0;
        req_1_i   = 1'b0;
        stalls    = stall_cnt;
    endtask

    lane_t none, a, b;
    int    st, wr0;
    logic  got;

    initial begin
        none = mk_lane(0, 0, 3'd0, 32'd0, 32'd0, 32'd0, 0);
        #12;
        check("rst_state", state_o, 0);
        check("rst_outputs", {mem_stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o}, 0);
        check("rst_ld_mis", {ld_data_0_o, ld_data_1_o, misalign_0_o, misalign_1_o}, 0);
        @(posedge clock_i); #1;
        reset_n_i = 1'b1;
        @(negedge clock_i); #1;
        chk_en = 1'b1;

        // single LW, zero-wait memory
        a = mk_lane(1, 0, 3'b010, 32'h100, 0, 32'hDEAD_BEEF, 0);
        run_bundle(a, none, 0, st);
        check("t1_stall", st, 2);
        check("t1_req_pulses", req_cyc, 1);
        check("t1_ld0", ld_data_0_o, 32'hDEAD_BEEF);

        // dual: SB then LH
        a = mk_lane(1, 1, 3'b000, 32'h203, 32'h0000_00AB, 0, 0);
        b = mk_lane(1, 0, 3'b001, 32'h202, 0, 32'hAB12_0000, 0);
        run_bundle(a, b, 0, st);
        check("t2_stall", st, 3);
        check("t2_be", last_be, 4'b1000);
        check("t2_wdata", last_wdata, 32'hABAB_ABAB);
        check("t2_ld1", ld_data_1_o, 32'hFFFF_AB12);
        check("t2_ld0_kept", ld_data_0_o, 32'hDEAD_BEEF);

        // dual, lane 0 acked after two wait states
        a = mk_lane(1, 0, 3'b010, 32'h10, 0, 32'h1122_3344, 2);
        b = mk_lane(1, 0, 3'b100, 32'h21, 0, 32'h0000_C500, 0);
        run_bundle(a, b, 0, st);
        check("t3_stall", st, 5);
        check("t3_req_cycles", req_cyc, 4);
        check("t3_ld1", ld_data_1_o, 32'h0000_00C5);

        // store held in DONE for four cycles
        wr0 = wr_cnt;
        a = mk_lane(1, 1, 3'b010, 32'h40, 32'h1234_5678, 0, 0);
        run_bundle(a, none, 4, st);
        check("t4_one_write", wr_cnt - wr0, 1);
        check("t4_stall", st, 2);

        // misaligned LW is skipped
        a = mk_lane(1, 0, 3'b010, 32'h102, 0, 32'h7777_7777, 0);
        run_bundle(a, none, 0, st);
        check("t5_req_cycles", req_cyc, 0);
        check("t5_mis0", misalign_0_o, 1);
        check("t5_ld0", ld_data_0_o, 0);
        check("t5_stall", st, 2);

        // next bundle clears the flag
        b = mk_lane(1, 0, 3'b000, 32'h33, 0, 32'h8000_0000, 0);
        run_bundle(none, b, 0, st);
        check("t6_mis0_clear", misalign_0_o, 0);
        check("t6_ld1", ld_data_1_o, 32'hFFFF_FF80);

        // empty bundle
        run_bundle(none, none, 1, st);
        check("t7_stall", st, 0);

        // lane 0 LHU, lane 1 misaligned LW
        a = mk_lane(1, 0, 3'b101, 32'h52, 0, 32'h9ABC_0000, 0);
        b = mk_lane(1, 0, 3'b010, 32'h51, 0, 32'h5555_5555, 0);
        run_bundle(a, b, 0, st);
        check("t8_ld0", ld_data_0_o, 32'h0000_9ABC);
        check("t8_mis1", {misalign_0_o, misalign_1_o}, 2'b01);
        check("t8_stall", st, 3);

        // SH upper half, then LW with one wait state
        a = mk_lane(1, 1, 3'b001, 32'h46, 32'h1234_BEEF, 0, 0);
        b = mk_lane(1, 0, 3'b010, 32'h48, 0, 32'h0BAD_F00D, 1);
        run_bundle(a, b, 0, st);
        check("t9_be", last_be, 4'b1100);
        check("t9_wdata", last_wdata, 32'hBEEF_BEEF);
        check("t9_stall", st, 4);

        // reset while lane 1 waits for ack
        a = mk_lane(1, 0, 3'b010, 32'h300, 0, 32'h55, 0);
        b = mk_lane(1, 0, 3'b010, 32'h304, 0, 32'h66, 40);
        push_lane(a);
        push_lane(b);
        @(posedge clock_i); #1;
        drive_lanes(a, b);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock_i); #1;
            if (state_o == 2'd2) begin got = 1'b1; break; end
        end
        check("t10_reach_l1", got, 1);
        check("t10_pre_rst_ld0", ld_data_0_o, 32'h55);
        chk_en    = 1'b0;
        force_ack = 1'b0;
        reset_n_i = 1'b0;
        #1;
        check("t10_rst_req", dmem_req_o, 0);
        check("t10_rst_stall", mem_stall_o, 0);
        check("t10_rst_state", state_o, 0);
        check("t10_rst_ld0", ld_data_0_o, 0);
        exp_q.delete();
        wait_cnt = 0;
        exp_ld0 = 32'd0; exp_ld1 = 32'd0; exp_mis0 = 1'b0; exp_mis1 = 1'b0;
        req_0_i = 1'b0;
        req_1_i = 1'b0;
        @(posedge clock_i); #1;
        reset_n_i = 1'b1;
        force_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock_i); #1;
            check("t10_late_ack", {state_o, dmem_req_o, mem_stall_o, ld_data_1_o}, 0);
        end
        force_ack = 1'b0;
        @(negedge clock_i); #1;
        chk_en = 1'b1;

        // normal operation after reset
        a = mk_lane(1, 0, 3'b000, 32'h61, 0, 32'h0000_FE00, 0);
        run_bundle(a, none, 0, st);
        check("t11_ld0", ld_data_0_o, 32'hFFFF_FFFE);
        check("t11_stall", st, 2);

        repeat (3) @(posedge clock_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, n_chk=%0d n_fail=%0d", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
